uart_tx_frame: RTL and testbench

Parametrised UART transmitter. It serialises one parallel word per frame onto the line, with configurable data width, optional even/odd parity and 1 or 2 stop bits. Baud timing and the bit counter are internal, and a valid/ready handshake replaces the Sent/Busy level protocol. It sits between the host-side command logic and the `tx` pin, and is the drop-in successor to the fixed 8N1 transmitter state machine plus its external counters.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_baud_gen.sv | 40 ++++
 rtl/uart_tx_frame.sv | 158 +++++++++++++++
 tb/tb_uart_tx_frame.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default baud divisor and parity modes.
// Used by the transmitter today and by the receiver later.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int UART_CLKS_115200 = 868;

  localparam logic PARITY_MODE_EVEN = 1'b0;
  localparam logic PARITY_MODE_ODD  = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the bit boundary.
// pre_tick fires one cycle ahead of tick so callers can register boundary-aligned outputs.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick,
  output logic pre_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick     = enable && (cnt_q == CNT_LAST);
  assign pre_tick = enable && (cnt_q == CNT_PRE);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter with valid/ready intake: start bit, DATA_BITS LSB-first, optional
// parity, 1 or 2 stop bits. Every output is a flop fed from the next-state logic.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = UART_CLKS_115200,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);
  localparam logic PAR_MODE = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be in 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
  end
  if (PARITY_EN != 0 && PARITY_EN != 1) begin : g_bad_parity_en
    $error("uart_tx_frame: PARITY_EN must be 0 or 1");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end

  uart_state_e          state_q, state_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 busy_q, busy_d;
  logic                 tx_done_q, tx_done_d;
  logic                 hs, tick, pre_tick;

  assign hs = tx_valid && tx_ready_q;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear   (hs),
    .enable  (state_q != ST_IDLE),
    .tick    (tick),
    .pre_tick(pre_tick)
  );

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          state_d = ST_START;
          bit_d   = '0;
          shift_d = tx_data;
          par_d   = (^tx_data) ^ PAR_MODE;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_DATA) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
          bit_d   = '0;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (bit_q == LAST_STOP) begin
            state_d = ST_IDLE;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level is derived from the next state so tx changes on the same edge as state.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase

    tx_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
    tx_done_d  = (state_q == ST_STOP) && (bit_q == LAST_STOP) && pre_tick;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_q      <= '0;
      tx_q       <= 1'b1;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      tx_done_q  <= tx_done_d;
    end
  end

  // Payload registers are only meaningful after a handshake loads them.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    par_q   <= par_d;
  end

  assign tx       = tx_q;
  assign tx_ready = tx_ready_q;
  assign busy     = busy_q;
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four configurations (8N1, 8E1, 8O1, 5N2) at 4 clocks per bit,
// compared cycle by cycle against a frame-slot model of the serial line.
module tb_uart_tx_frame;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       valid_a, valid_p;

  logic a_ready, a_tx, a_busy, a_done;
  logic e_ready, e_tx, e_busy, e_done;
  logic o_ready, o_tx, o_busy, o_done;
  logic d_ready, d_tx, d_busy, d_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid_a),
    .tx_ready(a_ready), .tx(a_tx), .busy(a_busy), .tx_done(a_done));

  uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_e (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid_p),
    .tx_ready(e_ready), .tx(e_tx), .busy(e_busy), .tx_done(e_done));

  uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_o (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid_p),
    .tx_ready(o_ready), .tx(o_tx), .busy(o_busy), .tx_done(o_done));

  uart_tx_frame #(.DATA_BITS(5), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_d (
    .clk(clk), .rst(rst), .tx_data(tx_data[4:0]), .tx_valid(valid_p),
    .tx_ready(d_ready), .tx(d_tx), .busy(d_busy), .tx_done(d_done));

  // Line level k cycles after the handshake cycle: slot 0 start, then data LSB first,
  // then optional parity, then stop slots; anything outside the frame is idle high.
  function automatic logic exp_bit(input int db, input int pen, input int podd, input int sb,
                                   input logic [8:0] d, input int k);
    int   idx;
    logic p;
    if (k < 1) return 1'b1;
    idx = (k - 1) / CPB;
    if (idx >= 1 + db + pen + sb) return 1'b1;
    if (idx == 0) return 1'b0;
    if (idx <= db) return d[idx-1];
    if (pen != 0 && idx == db + 1) begin
      p = (podd != 0);
      for (int i = 0; i < db; i++) p = p ^ d[i];
      return p;
    end
    return 1'b1;
  endfunction

  task automatic chk(input string name, input int k, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s k=%0d actual=%b required=%b", name, k, got, exp);
    end
  endtask

  // k <= 0 means no frame in flight: idle expectations.
  task automatic chk_inst(input string nm, input int db, input int pen, input int podd, input int sb,
                          input logic [8:0] d, input int k,
                          input logic tx_v, input logic done_v, input logic busy_v, input logic ready_v);
    int   f;
    logic eb;
    f  = (1 + db + pen + sb) * CPB;
    eb = (k >= 1) && (k <= f);
    chk({nm, ".tx"},    k, tx_v,    exp_bit(db, pen, podd, sb, d, k));
    chk({nm, ".done"},  k, done_v,  (k == f));
    chk({nm, ".busy"},  k, busy_v,  eb);
    chk({nm, ".ready"}, k, ready_v, !eb);
  endtask

  task automatic chk_a(input int k, input logic [7:0] w);
    chk_inst("a8n1", 8, 0, 0, 1, {1'b0, w}, k, a_tx, a_done, a_busy, a_ready);
  endtask

  task automatic chk_all(input int k, input logic [7:0] w);
    chk_a(k, w);
    chk_inst("e8e1", 8, 1, 0, 1, {1'b0, w}, k, e_tx, e_done, e_busy, e_ready);
    chk_inst("o8o1", 8, 1, 1, 1, {1'b0, w}, k, o_tx, o_done, o_busy, o_ready);
    chk_inst("d5n2", 5, 0, 0, 2, {4'b0, w[4:0]}, k, d_tx, d_done, d_busy, d_ready);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(a_ready && e_ready && o_ready && d_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", n, (n >= 200), 1'b0);
  endtask

  typedef struct {
    logic [7:0] word;
    logic       par_e;
    logic       par_o;
    logic [9:0] frame_a;
    logic [7:0] frame_d;
  } vec_t;

  // One frame on every configuration; table-driven entries also check exact slot values.
  task automatic send_all(input vec_t v, input logic use_tab);
    wait_idle();
    @(negedge clk);
    tx_data = v.word;
    valid_a = 1'b1;
    valid_p = 1'b1;
    for (int k = 1; k <= 46; k++) begin
      @(negedge clk);
      valid_a = 1'b0;
      valid_p = 1'b0;
      chk_all(k, v.word);
      if (use_tab) begin
        if ((k - 1) % CPB == 1 && (k - 1) / CPB < 10)
          chk("tab.a_slot", k, a_tx, v.frame_a[(k-1)/CPB]);
        if ((k - 1) % CPB == 1 && (k - 1) / CPB < 8)
          chk("tab.d_slot", k, d_tx, v.frame_d[(k-1)/CPB]);
        if (k == 38) begin
          chk("tab.par_even", k, e_tx, v.par_e);
          chk("tab.par_odd",  k, o_tx, v.par_o);
        end
        if (k == 40) chk("tab.done40", k, a_done, 1'b1);
      end
      if (k == 5) tx_data = 8'($urandom);
    end
  endtask

  // 8N1 only; optionally raises tx_valid for one cycle at glitch_k while the frame runs.
  task automatic send_a(input logic [7:0] w, input int glitch_k);
    wait_idle();
    @(negedge clk);
    tx_data = w;
    valid_a = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      @(negedge clk);
      chk_a(k, w);
      valid_a = (k == glitch_k);
      if (k == 7) tx_data = ~w;
    end
  endtask

  vec_t tab[6];

  initial begin
    tab[0] = '{8'hA5, 1'b0, 1'b1, 10'b1_1010_0101_0, 8'b11_00101_0};
    tab[1] = '{8'h07, 1'b1, 1'b0, 10'b1_0000_0111_0, 8'b11_00111_0};
    tab[2] = '{8'h1F, 1'b1, 1'b0, 10'b1_0001_1111_0, 8'b11_11111_0};
    tab[3] = '{8'h00, 1'b0, 1'b1, 10'b1_0000_0000_0, 8'b11_00000_0};
    tab[4] = '{8'hFF, 1'b0, 1'b1, 10'b1_1111_1111_0, 8'b11_11111_0};
    tab[5] = '{8'h3C, 1'b0, 1'b1, 10'b1_0011_1100_0, 8'b11_11100_0};

    rst     = 1'b1;
    valid_a = 1'b0;
    valid_p = 1'b0;
    tx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk_all(0, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    chk_all(0, 8'h00);

    for (int i = 0; i < 6; i++) send_all(tab[i], 1'b1);

    for (int i = 0; i < 6; i++) begin
      vec_t r;
      r = '{8'($urandom), 1'b0, 1'b0, 10'd0, 8'd0};
      send_all(r, 1'b0);
    end

    // Back-to-back with tx_valid held: second START exactly F+1 cycles after the first.
    wait_idle();
    @(negedge clk);
    tx_data = 8'h01;
    valid_a = 1'b1;
    for (int k = 1; k <= 84; k++) begin
      @(negedge clk);
      if (k <= 41) chk_a(k, 8'h01);
      else         chk_a(k - 41, 8'h80);
      if (k == 20) tx_data = 8'h80;
      if (k == 42) valid_a = 1'b0;
    end

    // Reset in the middle of the third data bit abandons the frame without tx_done.
    wait_idle();
    @(negedge clk);
    tx_data = 8'hC3;
    valid_a = 1'b1;
    for (int k = 1; k <= 44; k++) begin
      @(negedge clk);
      valid_a = 1'b0;
      if (k <= 14) chk_a(k, 8'hC3);
      else         chk_a(0, 8'hC3);
      if (k == 14) rst = 1'b1;
      if (k == 15) rst = 1'b0;
    end
    send_a(8'h3C, 0);

    // tx_valid pulses while busy, including the tx_done cycle, are ignored.
    send_a(8'h5A, 10);
    send_a(8'h96, 40);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk_a(0, 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
